// File: rtl/z_norm_check.sv
// z_norm_check: streaming infinity-norm / squared-L2 check of centred-mod-Q z coefficients.
// Defining Z_NORM_INF_CHECK_EN builds max|z| tracking and the BINF compare; without it max_abs=0 and inf_ok=1.
module z_norm_check #(
    parameter logic [48:0]  Q      = 49'd549824583172097,
    parameter int           N_COEF = 1024,
    parameter logic [47:0]  BINF   = 48'd41954689765971,
    parameter logic [105:0] B2SQ   = 106'd1 << 100
) (
    input  logic         clk,
    input  logic         rst_n,
    // Handshake: Din is consumed on every cycle with din_flag=1 while busy accumulating (no backpressure);
    // Dout_flag is a single-cycle strobe and the verdict outputs hold until the next strobe.
    input  logic         din_flag,
    input  logic [48:0]  Din,
    input  logic         abort,
    output logic         busy,
    output logic         Dout_flag,
    output logic         pass,
    output logic         inf_ok,
    output logic         l2_ok,
    output logic         err,
    output logic [105:0] sq_sum,
    output logic [47:0]  max_abs
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_DONE} state_t;

    localparam logic [48:0] HALF = (Q - 49'd1) >> 1;
    localparam logic [10:0] LAST = 11'(N_COEF - 1);

    state_t        state, state_nxt;
    logic [10:0]   cnt;
    logic [1:0]    flush_cnt;
    logic          accept;

    logic [47:0]   abs_c;
    logic [47:0]   diff_c;
    logic          v1, v2;
    logic [47:0]   abs1;
    logic [95:0]   prod2;
    logic [105:0]  sq_acc;
    logic [106:0]  sum_c;
    logic [105:0]  sq_nxt;
    logic          rng_err, ovr_err;
    logic          l2_ok_c, inf_ok_c, err_c;

    assign accept = din_flag && !abort && (state == S_IDLE || state == S_ACC);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ACC;
            S_ACC:   if (accept && cnt == LAST) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt == 2'd2) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            flush_cnt <= '0;
        end else begin
            flush_cnt <= (state == S_FLUSH && !abort) ? flush_cnt + 2'd1 : 2'd0;
            if (abort)
                cnt <= '0;
            else if (state == S_IDLE)
                cnt <= accept ? 11'd1 : 11'd0;
            else if (state == S_ACC && accept)
                cnt <= cnt + 11'd1;
            else if (state == S_DONE)
                cnt <= '0;
        end
    end

    // Centred magnitude: values above (Q-1)/2 represent negatives; out-of-range inputs count as 0.
    always_comb begin
        diff_c = 48'(Q - Din);
        abs_c  = '0;
        if (Din < Q) begin
            if (Din <= HALF) abs_c = Din[47:0];
            else             abs_c = diff_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            abs1  <= '0;
            prod2 <= '0;
        end else if (abort) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            abs1  <= '0;
            prod2 <= '0;
        end else begin
            v1    <= accept;
            abs1  <= accept ? abs_c : 48'd0;
            v2    <= v1;
            prod2 <= {48'd0, abs1} * {48'd0, abs1};
        end
    end

    // A carry out of the 106-bit sum pins the accumulator at all-ones so l2_ok cannot pass by wrapping.
    assign sum_c  = {1'b0, sq_acc} + {11'd0, prod2};
    assign sq_nxt = sum_c[106] ? {106{1'b1}} : sum_c[105:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sq_acc <= '0;
        else if (abort || state == S_IDLE)
            sq_acc <= '0;
        else if (v2)
            sq_acc <= sq_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rng_err <= 1'b0;
            ovr_err <= 1'b0;
        end else if (abort) begin
            rng_err <= 1'b0;
            ovr_err <= 1'b0;
        end else if (state == S_IDLE) begin
            rng_err <= accept && (Din >= Q);
            ovr_err <= 1'b0;
        end else begin
            if (accept && Din >= Q) rng_err <= 1'b1;
            if (din_flag && (state == S_FLUSH || state == S_DONE)) ovr_err <= 1'b1;
        end
    end

`ifdef Z_NORM_INF_CHECK_EN
    logic [47:0] abs2;
    logic [47:0] max_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs2    <= '0;
            max_acc <= '0;
        end else if (abort) begin
            abs2    <= '0;
            max_acc <= '0;
        end else begin
            abs2 <= abs1;
            if (state == S_IDLE)
                max_acc <= '0;
            else if (v2 && abs2 > max_acc)
                max_acc <= abs2;
        end
    end

    assign inf_ok_c = (max_acc <= BINF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_abs <= '0;
        else if (state == S_DONE && !abort)
            max_abs <= max_acc;
    end
`else
    assign inf_ok_c = 1'b1;
    assign max_abs  = '0;
`endif

    assign l2_ok_c = (sq_acc <= B2SQ);
    assign err_c   = rng_err | ovr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dout_flag <= 1'b0;
            pass      <= 1'b0;
            inf_ok    <= 1'b0;
            l2_ok     <= 1'b0;
            err       <= 1'b0;
            sq_sum    <= '0;
        end else begin
            Dout_flag <= 1'b0;
            if (state == S_DONE && !abort) begin
                Dout_flag <= 1'b1;
                pass      <= inf_ok_c & l2_ok_c & ~err_c;
                inf_ok    <= inf_ok_c;
                l2_ok     <= l2_ok_c;
                err       <= err_c;
                sq_sum    <= sq_acc;
            end
        end
    end

endmodule

// File: tb/tb_z_norm_check.sv
// Directed bench for z_norm_check with N_COEF=4; a second instance with B2SQ=35 covers the L2 bound.
module tb_z_norm_check;

    localparam logic [48:0] QV = 49'd549824583172097;
    localparam logic [48:0] HV = 49'd274912291586048;

    logic         clk = 1'b0;
    logic         rst_n, din_flag, abort;
    logic [48:0]  Din;
    logic         busy, Dout_flag, pass, inf_ok, l2_ok, err;
    logic [105:0] sq_sum;
    logic [47:0]  max_abs;
    logic         b_busy, b_dout_flag, b_pass, b_inf_ok, b_l2_ok, b_err;
    logic [105:0] b_sq_sum;
    logic [47:0]  b_max_abs;

    int n_assert = 0;
    int n_fail = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [105:0] sq_a;

    z_norm_check #(.N_COEF(4)) dut (
        .clk(clk), .rst_n(rst_n), .din_flag(din_flag), .Din(Din), .abort(abort),
        .busy(busy), .Dout_flag(Dout_flag), .pass(pass), .inf_ok(inf_ok), .l2_ok(l2_ok),
        .err(err), .sq_sum(sq_sum), .max_abs(max_abs)
    );

    z_norm_check #(.N_COEF(4), .B2SQ(106'd35)) dut2 (
        .clk(clk), .rst_n(rst_n), .din_flag(din_flag), .Din(Din), .abort(abort),
        .busy(b_busy), .Dout_flag(b_dout_flag), .pass(b_pass), .inf_ok(b_inf_ok), .l2_ok(b_l2_ok),
        .err(b_err), .sq_sum(b_sq_sum), .max_abs(b_max_abs)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (Dout_flag) pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [48:0] v, input int gap);
        @(negedge clk);
        din_flag = 1'b1;
        Din = v;
        repeat (gap) begin
            @(negedge clk);
            din_flag = 1'b0;
        end
    endtask

    task automatic wait_result(input logic ovr);
        int lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            din_flag = (k == 1) ? ovr : 1'b0;
            if (k == 1) chk("busy_in_frame", busy, 1);
            if (Dout_flag) lat = k;
        end
        chk("latency", lat, 5);
        chk("busy_at_strobe", busy, 0);
    endtask

    task automatic run_frame(input logic [48:0] d0, d1, d2, d3, input int gap, input logic ovr);
        send(d0, gap);
        send(d1, gap);
        send(d2, gap);
        send(d3, 0);
        wait_result(ovr);
        exp_pulses++;
        @(negedge clk);
        chk("strobe_width", Dout_flag, 0);
    endtask

    task automatic verdict(input string nm, input logic ep, ei, el, ee,
                           input logic [105:0] es, input logic [47:0] em);
        chk({nm, ".pass"}, pass, ep);
        chk({nm, ".inf_ok"}, inf_ok, ei);
        chk({nm, ".l2_ok"}, l2_ok, el);
        chk({nm, ".err"}, err, ee);
        chk({nm, ".sq_sum"}, sq_sum, es);
`ifdef Z_NORM_INF_CHECK_EN
        chk({nm, ".max_abs"}, max_abs, em);
`else
        chk({nm, ".max_abs"}, max_abs, 48'd0);
`endif
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".dout_flag"}, Dout_flag, 0);
        chk({nm, ".pass"}, pass, 0);
        chk({nm, ".inf_ok"}, inf_ok, 0);
        chk({nm, ".l2_ok"}, l2_ok, 0);
        chk({nm, ".err"}, err, 0);
        chk({nm, ".sq_sum"}, sq_sum, 0);
        chk({nm, ".max_abs"}, max_abs, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        din_flag = 1'b0;
        abort = 1'b0;
        Din = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back: abs = 0, 1, 1, (Q-1)/2
        sq_a = {57'd0, HV} * {57'd0, HV} + 106'd2;
        run_frame(49'd0, 49'd1, QV - 49'd1, HV, 0, 1'b0);
`ifdef Z_NORM_INF_CHECK_EN
        verdict("frame_a", 1'b0, 1'b0, 1'b1, 1'b0, sq_a, HV[47:0]);
`else
        verdict("frame_a", 1'b1, 1'b1, 1'b1, 1'b0, sq_a, 48'd0);
`endif

        // Gapped: abs = 5, 3, 2, 0 -> 25+9+4
        run_frame(49'd5, QV - 49'd3, 49'd2, 49'd0, 1, 1'b0);
        verdict("frame_b", 1'b1, 1'b1, 1'b1, 1'b0, 106'd38, 48'd5);

        // Out-of-range third coefficient contributes 0: 1+4+16
        run_frame(49'd1, 49'd2, QV, 49'd4, 0, 1'b0);
        verdict("frame_c", 1'b0, 1'b1, 1'b1, 1'b1, 106'd21, 48'd4);

        // din_flag during FLUSH is ignored but flags an error
        run_frame(49'd1, 49'd1, 49'd1, 49'd1, 0, 1'b1);
        verdict("frame_ovr", 1'b0, 1'b1, 1'b1, 1'b1, 106'd4, 48'd1);

        // Abort after two accepts, with din_flag high in the abort cycle
        send(49'd9, 0);
        send(49'd9, 0);
        @(negedge clk);
        abort = 1'b1;
        Din = 49'd9;
        @(negedge clk);
        abort = 1'b0;
        din_flag = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.held_sq_sum", sq_sum, 106'd4);
        chk("abort.held_err", err, 1);
        repeat (8) @(negedge clk);
        chk("abort.no_strobe", pulses, exp_pulses);
        run_frame(49'd3, 49'd3, 49'd3, 49'd3, 0, 1'b0);
        verdict("frame_abort", 1'b1, 1'b1, 1'b1, 1'b0, 106'd36, 48'd3);
        chk("b2sq.l2_ok", b_l2_ok, 0);
        chk("b2sq.pass", b_pass, 0);
        chk("b2sq.sq_sum", b_sq_sum, 106'd36);
        chk("abort.one_strobe", pulses, exp_pulses);

        // Asynchronous reset mid-frame
        send(49'd7, 0);
        send(49'd7, 0);
        @(negedge clk);
        din_flag = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_reset.no_strobe", pulses, exp_pulses);
        run_frame(49'd7, 49'd7, 49'd7, 49'd7, 0, 1'b0);
        verdict("frame_post_reset", 1'b1, 1'b1, 1'b1, 1'b0, 106'd196, 48'd7);

        repeat (4) @(negedge clk);
        chk("total_strobes", pulses, exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/z_norm_check.md
Z_NORM_CHECK -- requirements
Module: z_norm_check

Interface
REQ-001 SHALL have parameter Q, default 549824583172097, the 49-bit odd modulus of incoming z coefficients.
REQ-002 SHALL have parameter N_COEF, default 1024, the number of coefficients per frame (range 2..2047).
REQ-003 SHALL have parameter BINF, default 41954689765971, the 48-bit infinity-norm bound (inclusive).
REQ-004 SHALL have parameter B2SQ, default 2^100, the 106-bit squared-L2 bound (inclusive).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port din_flag  input  1  Din valid this cycle (upstream Dout_sign_z_flag).
REQ-008 SHALL have port Din  input  49  z coefficient in [0,Q) (upstream Dout_sign_z).
REQ-009 SHALL have port abort  input  1  synchronous frame discard.
REQ-010 SHALL have port busy  output  1  high from frame start until Dout_flag.
REQ-011 SHALL have port Dout_flag  output  1  one-cycle result strobe.
REQ-012 SHALL have port pass, inf_ok, l2_ok, err  output  1 each  verdict bits, valid while Dout_flag is high and held until the next frame result.
REQ-013 SHALL have port sq_sum  output  106  final squared-L2 sum, held with the verdict.
REQ-014 SHALL have port max_abs  output  48  final max |z|, held with the verdict.

Function
REQ-015 SHALL implement FSM IDLE -> ACC -> FLUSH -> DONE -> IDLE.
REQ-016 IDLE: accumulators clear; the first din_flag=1 starts a frame, counts as coefficient 0 and moves to ACC.
REQ-017 ACC: each din_flag=1 cycle accepts one coefficient; gaps (din_flag=0) are allowed and not counted; 11-bit counter increments per accept.
REQ-018 The accept of coefficient N_COEF-1 SHALL move to FLUSH.
REQ-019 FLUSH SHALL last 3 cycles to drain the pipeline, then move to DONE; DONE lasts 1 cycle and then returns to IDLE.
REQ-020 Pipeline: stage 1 registers abs = Din if Din <= (Q-1)/2, else Q-Din; stage 2 registers the 96-bit abs*abs; stage 3 accumulates into 106-bit sq_acc and updates max_acc = max(max_acc, abs).
REQ-021 Din >= Q SHALL set sticky rng_err and contribute abs=0.
REQ-022 din_flag=1 in FLUSH or DONE SHALL be ignored and set sticky ovr_err.
REQ-023 In DONE: l2_ok = (sq_acc <= B2SQ); inf_ok = (max_acc <= BINF); err = rng_err | ovr_err; pass = inf_ok & l2_ok & ~err; all registered with Dout_flag=1.
REQ-024 Latency: Dout_flag SHALL be high in exactly the 5th cycle after the edge sampling the last coefficient; it is never high for more than one cycle.
REQ-025 sq_acc SHALL NOT wrap; any carry out of bit 105 saturates to all-ones (forcing l2_ok=0).
REQ-026 abort=1 SHALL return the FSM to IDLE next edge, clear the counter, accumulators and sticky errors, suppress Dout_flag, and leave the held verdict outputs unchanged; abort has priority over din_flag in the same cycle.
REQ-027 din_flag=1 in the DONE cycle SHALL NOT start a new frame; the first accept of the next frame is in IDLE.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE and zero all registers; outputs busy, Dout_flag, pass, inf_ok, l2_ok and err are 0, and sq_sum and max_abs are 0.
REQ-029 Reset mid-frame SHALL discard the frame with no Dout_flag; after rst_n rises, operation starts at IDLE.

Configuration
REQ-030 With macro Z_NORM_INF_CHECK_EN defined, max tracking and the BINF compare SHALL be built as in REQ-020/023.
REQ-031 Without Z_NORM_INF_CHECK_EN, max logic SHALL be omitted; max_abs=0 and inf_ok=1 constantly, and pass depends only on l2_ok and err.

Verification
REQ-032 N_COEF=4, Din = 0, 1, Q-1, (Q-1)/2 back-to-back -> Dout_flag 5 cycles after the last accept; sq_sum=2+((Q-1)/2)^2; max_abs=(Q-1)/2; inf_ok=0, l2_ok=1, pass=0.
REQ-033 N_COEF=4, Din = 5, Q-3, 2, 0 with one idle cycle between each -> sq_sum=38, max_abs=5, pass=1, err=0.
REQ-034 N_COEF=4, third Din=Q -> err=1 and pass=0; the abs of that coefficient counts as 0 in sq_sum.
REQ-035 N_COEF=4, accept 2 coefficients, assert abort, then send 4 coefficients of value 3 -> exactly one Dout_flag, with sq_sum=36.
REQ-036 Drop rst_n mid-frame after 2 accepts -> all outputs 0 immediately; no Dout_flag; a following full frame gives a correct result.
REQ-037 B2SQ=35, N_COEF=4, Din=3 x4 -> l2_ok=0, pass=0; build without Z_NORM_INF_CHECK_EN and rerun REQ-032 -> inf_ok=1, max_abs=0.
